// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and the decode stage.
`timescale 1ns/1ps
package fetch_pkg;

   localparam int ADDR_W = 16;
   localparam int INST_W = 9;

   // Decode also uses this word to recognise the end of the program.
   localparam logic [INST_W-1:0] HALT_INST_DEFAULT = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      HALTED
   } fetch_state_t;

   // Next-PC sources; HOLD keeps the PC frozen during stalls and drain.
   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INC,
      PC_TARGET,
      PC_START
   } pc_sel_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC mux (hold / +1 / branch target / start address).
`timescale 1ns/1ps
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int             A          = ADDR_W,
   parameter logic [A-1:0]   START_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  pc_sel_t       pc_sel,
   input  logic [A-1:0]  target,
   output logic [A-1:0]  pc
);

   logic [A-1:0] pc_q;
   logic [A-1:0] pc_d;

   // Select the next PC; the increment wraps naturally at 2^A.
   always_comb begin
      pc_d = pc_q;
      case (pc_sel)
         PC_HOLD:   pc_d = pc_q;
         PC_INC:    pc_d = pc_q + A'(1);
         PC_TARGET: pc_d = target;
         PC_START:  pc_d = START_ADDR;
         default:   pc_d = pc_q;
      endcase
   end

   // PC register, returns to the start address on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= START_ADDR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: drives the ROM address, registers returned words into a valid/ready
// stage for decode, applies branch redirects and stops after delivering the halt word.
`timescale 1ns/1ps
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int           A          = ADDR_W,
   parameter int           W          = INST_W,
   parameter logic [A-1:0] START_ADDR = '0,
   parameter logic [W-1:0] HALT_INST  = '1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   output logic [A-1:0]  InstAddress,
   input  logic [W-1:0]  InstIn,
   output logic [W-1:0]  Inst,
   output logic [A-1:0]  InstPC,
   output logic          InstValid,
   input  logic          InstReady,
   input  logic          BranchEn,
   input  logic [A-1:0]  BranchTarget,
   output logic          Done
);

   fetch_state_t  state_q;
   fetch_state_t  state_d;
   logic [W-1:0]  inst_q;
   logic [W-1:0]  inst_d;
   logic [A-1:0]  inst_pc_q;
   logic [A-1:0]  inst_pc_d;
   logic          inst_valid_q;
   logic          inst_valid_d;
   pc_sel_t       pc_sel;
   logic [A-1:0]  pc;
   logic          fetch;
   logic          transfer;

   fetch_pc #(
      .A          (A),
      .START_ADDR (START_ADDR)
   ) u_fetch_pc (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .pc_sel (pc_sel),
      .target (BranchTarget),
      .pc     (pc)
   );

   // A new word is captured whenever the output slot is free or draining, unless redirecting.
   assign fetch    = (state_q == RUN) && (!inst_valid_q || InstReady) && !BranchEn;
   assign transfer = inst_valid_q && InstReady;

   // Next state, output-stage update and PC source; redirect has priority over fetch and halt.
   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      pc_sel       = PC_HOLD;
      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               state_d = RUN;
               pc_sel  = PC_START;
            end
         end
         RUN, DRAIN: begin
            if (BranchEn) begin
               state_d      = RUN;
               pc_sel       = PC_TARGET;
               inst_valid_d = 1'b0;
            end else if (fetch) begin
               inst_d       = InstIn;
               inst_pc_d    = pc;
               inst_valid_d = 1'b1;
               pc_sel       = PC_INC;
               if (InstIn == HALT_INST) begin
                  state_d = DRAIN;
               end
            end else if (transfer) begin
               inst_valid_d = 1'b0;
               if (state_q == DRAIN) begin
                  state_d = HALTED;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output-stage registers, cleared asynchronously.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign InstAddress = pc;
   assign Inst        = inst_q;
   assign InstPC      = inst_pc_q;
   assign InstValid   = inst_valid_q;
   assign Done        = (state_q == HALTED);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a vector table walks streaming, backpressure,
// redirect, wrap, halt and restart; hand sequences cover async reset and IDLE behaviour.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

   localparam int A = 16;
   localparam int W = 9;
   localparam int NUM_VECS = 30;

   logic          Clk;
   logic          Reset_n;
   logic          Start;
   logic [A-1:0]  InstAddress;
   logic [W-1:0]  InstIn;
   logic [W-1:0]  Inst;
   logic [A-1:0]  InstPC;
   logic          InstValid;
   logic          InstReady;
   logic          BranchEn;
   logic [A-1:0]  BranchTarget;
   logic          Done;

   int total_checks;
   int bad_checks;

   typedef struct {
      logic          start;
      logic          ready;
      logic          br;
      logic [A-1:0]  tgt;
      logic          exp_valid;
      logic [W-1:0]  exp_inst;
      logic [A-1:0]  exp_pc;
      logic [A-1:0]  exp_addr;
      logic          exp_done;
   } vec_t;

   vec_t vecs [NUM_VECS];

   inst_fetch_ctrl dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .InstAddress  (InstAddress),
      .InstIn       (InstIn),
      .Inst         (Inst),
      .InstPC       (InstPC),
      .InstValid    (InstValid),
      .InstReady    (InstReady),
      .BranchEn     (BranchEn),
      .BranchTarget (BranchTarget),
      .Done         (Done)
   );

   // Known program image: 0..3 stream ending in halt, a second block at 0x10, and the top word.
   function automatic logic [W-1:0] rom_word(input logic [A-1:0] addr);
      case (addr)
         16'h0000: return 9'h001;
         16'h0001: return 9'h002;
         16'h0002: return 9'h003;
         16'h0003: return 9'h1FF;
         16'h0010: return 9'h0A5;
         16'h0011: return 9'h0A6;
         16'h0012: return 9'h1FF;
         16'hFFFF: return 9'h155;
         default:  return 9'h0AA ^ addr[8:0];
      endcase
   endfunction

   // Combinational ROM read, same cycle as the address.
   always_comb begin
      InstIn = rom_word(InstAddress);
   end

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [A-1:0] t,
                               input logic v, input logic [W-1:0] i, input logic [A-1:0] p,
                               input logic [A-1:0] a, input logic d);
      vec_t x;
      x.start = s; x.ready = r; x.br = b; x.tgt = t;
      x.exp_valid = v; x.exp_inst = i; x.exp_pc = p; x.exp_addr = a; x.exp_done = d;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic b, input logic [A-1:0] t);
      Start        = s;
      InstReady    = r;
      BranchEn     = b;
      BranchTarget = t;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " valid"}, 32'(InstValid), 32'h0);
      checkOutput({tag, " inst"},  32'(Inst),      32'h0);
      checkOutput({tag, " instpc"},32'(InstPC),    32'h0);
      checkOutput({tag, " addr"},  32'(InstAddress), 32'h0);
      checkOutput({tag, " done"},  32'(Done),      32'h0);
   endtask

   initial begin
      total_checks = 0;
      bad_checks   = 0;
      Reset_n      = 1'b0;
      Start        = 1'b0;
      InstReady    = 1'b0;
      BranchEn     = 1'b0;
      BranchTarget = '0;

      //            start rdy br  tgt       valid inst    instpc    addr      done
      vecs[0]  = mk(1, 1, 0, 16'h0000, 0, 9'h000, 16'h0000, 16'h0000, 0);
      vecs[1]  = mk(0, 1, 0, 16'h0000, 1, 9'h001, 16'h0000, 16'h0001, 0);
      vecs[2]  = mk(0, 1, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[3]  = mk(0, 1, 0, 16'h0000, 1, 9'h003, 16'h0002, 16'h0003, 0);
      vecs[4]  = mk(0, 1, 0, 16'h0000, 1, 9'h1FF, 16'h0003, 16'h0004, 0);
      vecs[5]  = mk(0, 1, 0, 16'h0000, 0, 9'h1FF, 16'h0003, 16'h0004, 1);
      vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 9'h1FF, 16'h0003, 16'h0004, 1);
      vecs[7]  = mk(1, 0, 0, 16'h0000, 0, 9'h1FF, 16'h0003, 16'h0000, 0);
      vecs[8]  = mk(0, 1, 0, 16'h0000, 1, 9'h001, 16'h0000, 16'h0001, 0);
      vecs[9]  = mk(0, 1, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[10] = mk(0, 0, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[11] = mk(0, 0, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[12] = mk(0, 0, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[13] = mk(0, 1, 0, 16'h0000, 1, 9'h003, 16'h0002, 16'h0003, 0);
      vecs[14] = mk(0, 0, 1, 16'h0010, 0, 9'h003, 16'h0002, 16'h0010, 0);
      vecs[15] = mk(0, 0, 0, 16'h0000, 1, 9'h0A5, 16'h0010, 16'h0011, 0);
      vecs[16] = mk(0, 1, 0, 16'h0000, 1, 9'h0A6, 16'h0011, 16'h0012, 0);
      vecs[17] = mk(0, 1, 0, 16'h0000, 1, 9'h1FF, 16'h0012, 16'h0013, 0);
      vecs[18] = mk(0, 0, 0, 16'h0000, 1, 9'h1FF, 16'h0012, 16'h0013, 0);
      vecs[19] = mk(0, 1, 1, 16'hFFFF, 0, 9'h1FF, 16'h0012, 16'hFFFF, 0);
      vecs[20] = mk(0, 1, 0, 16'h0000, 1, 9'h155, 16'hFFFF, 16'h0000, 0);
      vecs[21] = mk(0, 1, 0, 16'h0000, 1, 9'h001, 16'h0000, 16'h0001, 0);
      vecs[22] = mk(1, 1, 0, 16'h0000, 1, 9'h002, 16'h0001, 16'h0002, 0);
      vecs[23] = mk(0, 1, 0, 16'h0000, 1, 9'h003, 16'h0002, 16'h0003, 0);
      vecs[24] = mk(0, 1, 0, 16'h0000, 1, 9'h1FF, 16'h0003, 16'h0004, 0);
      vecs[25] = mk(1, 0, 0, 16'h0000, 1, 9'h1FF, 16'h0003, 16'h0004, 0);
      vecs[26] = mk(0, 1, 0, 16'h0000, 0, 9'h1FF, 16'h0003, 16'h0004, 1);
      vecs[27] = mk(0, 0, 1, 16'h0010, 0, 9'h1FF, 16'h0003, 16'h0004, 1);
      vecs[28] = mk(1, 0, 0, 16'h0000, 0, 9'h1FF, 16'h0003, 16'h0000, 0);
      vecs[29] = mk(0, 1, 0, 16'h0000, 1, 9'h001, 16'h0000, 16'h0001, 0);

      // Power-on reset held across a few edges.
      repeat (3) @(posedge Clk);
      #1;
      checkReset("por");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // Table walk; Inst/InstPC are only meaningful while InstValid is high.
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].start, vecs[i].ready, vecs[i].br, vecs[i].tgt);
         checkOutput($sformatf("row%0d valid", i), 32'(InstValid),   32'(vecs[i].exp_valid));
         checkOutput($sformatf("row%0d addr", i),  32'(InstAddress), 32'(vecs[i].exp_addr));
         checkOutput($sformatf("row%0d done", i),  32'(Done),        32'(vecs[i].exp_done));
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("row%0d inst", i),   32'(Inst),   32'(vecs[i].exp_inst));
            checkOutput($sformatf("row%0d instpc", i), 32'(InstPC), 32'(vecs[i].exp_pc));
         end
      end

      // Asynchronous reset dropped mid-RUN between clock edges.
      Start     = 1'b0;
      InstReady = 1'b0;
      BranchEn  = 1'b0;
      #3;
      Reset_n = 1'b0;
      #1;
      checkReset("async");
      repeat (2) @(posedge Clk);
      #2;
      checkReset("held");
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // Branch and idle cycles in IDLE leave the sequencer parked at the start address.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
      checkOutput("idle br addr",  32'(InstAddress), 32'h0);
      checkOutput("idle br valid", 32'(InstValid),   32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("idle addr",  32'(InstAddress), 32'h0);
      checkOutput("idle valid", 32'(InstValid),   32'h0);

      // Start after reset: first word is ROM[0] one edge after RUN is entered.
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput("start valid", 32'(InstValid), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("first valid",  32'(InstValid),   32'h1);
      checkOutput("first inst",   32'(Inst),        32'h001);
      checkOutput("first instpc", 32'(InstPC),      32'h0);
      checkOutput("first addr",   32'(InstAddress), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("second inst",   32'(Inst),   32'h002);
      checkOutput("second instpc", 32'(InstPC), 32'h1);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
